frm_pixel_op: RTL and testbench
===============================

# frm_pixel_op

Parametrised per-pixel point-operation stage on the team's frame interface (val/rdy plus sof/eof/sol/eol). It generalises the fixed single-mode negation stage to any channel count and channel width. It adds four per-frame-selectable modes (bypass, negate, threshold, grayscale) and a 2-stage backpressure-safe pipeline with line-length checking. It sits between the AXI-stream-to-frame converter and the S2MM video path.

## Interface
- CH_NUM, 3: channels per pixel; channel k occupies bits [k*CH_W +: CH_W]; channel 0 = B, 1 = G, 2 = R
- CH_W, 8: bits per channel; data width DW = CH_NUM*CH_W
- IMG_W_W, 11: width of the line-length config and pixel counter
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous reset, active low
- cfg_img_w  in  IMG_W_W  pixels per line; legal range is 1 or more
- cfg_mode  in  2  0 = bypass, 1 = negate, 2 = threshold, 3 = grayscale
- cfg_thr  in  CH_W  threshold for mode 2
- m_frm_val / m_frm_rdy  in / out  1  input-side handshake
- m_frm_data  in  DW  input pixel
- m_frm_sof, m_frm_eof, m_frm_sol, m_frm_eol  in  1 each  input frame markers
- s_frm_val / s_frm_rdy  out / in  1  output-side handshake
- s_frm_data  out  DW  processed pixel
- s_frm_sof, s_frm_eof, s_frm_sol, s_frm_eol  out  1 each  markers, delayed in step with data
- err_line_len  out  1  one-cycle pulse on a line-length violation
- frm_done  out  1  one-cycle pulse when the eof beat is accepted at the output

## Operation
- Config latch: cfg_mode and cfg_thr are captured on the accepted input beat that carries sof, and the captured value also applies to that beat. The captured value holds until the next sof. The reset value of the latched mode is bypass; the reset value of the latched threshold is 0.
- Bypass: output equals input.
- Negate: each channel becomes its bitwise complement (2^CH_W-1 minus the channel value).
- Threshold: each channel becomes all ones if it is greater than or equal to the threshold, otherwise 0.
- Grayscale: Y = (77*R + 150*G + 29*B) >> 8.
  - The product sum is CH_W+8 bits wide. The coefficients sum to 256, so Y never exceeds 2^CH_W-1 and no saturation is needed.
  - Y is replicated to R, G and B; channels at index 3 and above pass through unchanged.
  - When CH_NUM is less than 3, mode 3 behaves as bypass.
- Markers are not modified; they travel with their pixel.
- Line check: the pixel counter increments on each accepted input beat and clears on eol, on sof, and on reset.
  - err_line_len pulses if eol arrives when the counter is not equal to cfg_img_w-1.
  - err_line_len also pulses if the counter reaches cfg_img_w-1 without eol on that beat; the counter then clears.
  - The pixel is never dropped or altered because of a line-length error.

## Timing
- Pipeline stages: S1 registers the input and the channel products. S2 registers the final result and the markers.
- Latency: 2 cycles from input acceptance to s_frm_val. Throughput is 1 pixel per cycle when s_frm_rdy is held high.
- Stage advance: adv2 = !s2_val | s_frm_rdy; adv1 = !s1_val | adv2; m_frm_rdy = adv1.
  - The path from s_frm_rdy to m_frm_rdy is combinational. This is permitted.
- While s_frm_val is high and s_frm_rdy is low, s_frm_data and the markers hold stable. No beat is lost or duplicated.
- Reset values: s_frm_val 0, s_frm_data 0, all output markers 0, err_line_len 0, frm_done 0. After reset, m_frm_rdy is 1.
- Reset mid-frame: all in-flight beats are discarded, the counter clears, and the latched mode reverts to bypass.
- sof and eof on the same beat (1-pixel frame): the config latch applies to that beat, and frm_done pulses when it exits.
- A config change in the middle of a frame has no effect until the next sof.

## Structure
- Package frm_pkg holds the mode encodings (MODE_BYP, MODE_NEG, MODE_THR, MODE_GRAY) and the luma coefficient constants (77, 150, 29).
- One sub-module, frm_px_alu: a combinational per-pixel operation taking mode, threshold and pixel. It is instantiated between S1 and S2.

## Test plan
- Bypass, CH_NUM=3, CH_W=8, 4x2 frame, s_frm_rdy held at 1 -> output matches input exactly, arriving 2 cycles after input, with markers aligned and frm_done pulsing once.
- Negate, pixel 0x102030 -> output 0xEFDFCF.
- Threshold with cfg_thr=0x80, pixel 0x7F8081 -> output 0x00FFFF.
- Grayscale:
  - Pixel R=0xFF, G=0xFF, B=0xFF -> 0xFFFFFF.
  - Pixel R=0x64, G=0, B=0 -> 0x1E1E1E.
- Backpressure: s_frm_rdy toggled randomly over 100 beats -> output sequence equals the model, with no data change while stalled.
  - cfg_mode changed in the middle of a frame -> takes effect only from the next sof.
- Line check and reset:
  - With cfg_img_w=4, a line with eol on the 3rd pixel -> exactly one err_line_len pulse.
  - rst_n asserted mid-frame -> s_frm_val goes to 0 immediately, and the next frame is processed in bypass until an sof latches a new mode.

Source files
------------

// File: rtl/frm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frm_pkg
// Description : Shared types and constants for the frame pixel-op stage:
//               operating-mode encodings and luma coefficients.
// Revision    : 1.0 - initial release
// ============================================================================
package frm_pkg;

    // Per-frame operating mode, latched on the sof beat
    typedef enum logic [1:0] {
        MODE_BYP  = 2'd0,
        MODE_NEG  = 2'd1,
        MODE_THR  = 2'd2,
        MODE_GRAY = 2'd3
    } frm_mode_e;

    // Luma weights sum to 256, so the shifted sum always fits in one channel
    localparam int unsigned LUMA_R     = 77;
    localparam int unsigned LUMA_G     = 150;
    localparam int unsigned LUMA_B     = 29;
    localparam int unsigned LUMA_SHIFT = 8;

endpackage
`default_nettype wire

// File: rtl/frm_px_alu.sv
`default_nettype none
// ============================================================================
// Module      : frm_px_alu
// Description : Combinational per-pixel point operation (bypass, negate,
//               threshold, grayscale). The luma product sum is computed and
//               registered upstream; this block only selects and shifts it.
// Revision    : 1.0 - initial release
// ============================================================================
module frm_px_alu
    import frm_pkg::*;
#(
    parameter int CH_NUM = 3,
    parameter int CH_W   = 8
) (
    input  frm_mode_e                      mode_i,
    input  logic [CH_W-1:0]                thr_i,
    input  logic [CH_NUM*CH_W-1:0]         pix_i,
    input  logic [CH_W+LUMA_SHIFT-1:0]     luma_i,
    output logic [CH_NUM*CH_W-1:0]         pix_o
);

    logic [CH_W-1:0] w_ch;
    logic            w_unused_luma_lo;

    // Fractional bits of the luma sum are discarded by the shift
    assign w_unused_luma_lo = ^luma_i[LUMA_SHIFT-1:0];

    // Apply the selected operation channel by channel
    always_comb begin
        pix_o = pix_i;
        w_ch  = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            w_ch = pix_i[k*CH_W +: CH_W];
            case (mode_i)
                MODE_NEG: pix_o[k*CH_W +: CH_W] = ~w_ch;
                MODE_THR: pix_o[k*CH_W +: CH_W] = (w_ch >= thr_i) ? {CH_W{1'b1}} : {CH_W{1'b0}};
                MODE_GRAY: begin
                    // Only B, G, R are replaced; narrower pixels fall back to bypass
                    if (CH_NUM >= 3 && k < 3)
                        pix_o[k*CH_W +: CH_W] = luma_i[LUMA_SHIFT +: CH_W];
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/frm_pixel_op.sv
`default_nettype none
// ============================================================================
// Module      : frm_pixel_op
// Description : Two-stage backpressure-safe per-pixel point-operation stage
//               on the val/rdy frame interface, with per-frame mode latch
//               and line-length checking.
// Revision    : 1.0 - initial release
// ============================================================================
module frm_pixel_op
    import frm_pkg::*;
#(
    parameter int CH_NUM  = 3,
    parameter int CH_W    = 8,
    parameter int IMG_W_W = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [IMG_W_W-1:0]       cfg_img_w,
    input  logic [1:0]               cfg_mode,
    input  logic [CH_W-1:0]          cfg_thr,
    input  logic                     m_frm_val,
    output logic                     m_frm_rdy,
    input  logic [CH_NUM*CH_W-1:0]   m_frm_data,
    input  logic                     m_frm_sof,
    input  logic                     m_frm_eof,
    input  logic                     m_frm_sol,
    input  logic                     m_frm_eol,
    output logic                     s_frm_val,
    input  logic                     s_frm_rdy,
    output logic [CH_NUM*CH_W-1:0]   s_frm_data,
    output logic                     s_frm_sof,
    output logic                     s_frm_eof,
    output logic                     s_frm_sol,
    output logic                     s_frm_eol,
    output logic                     err_line_len,
    output logic                     frm_done
);

    localparam int DW    = CH_NUM * CH_W;
    localparam int SUM_W = CH_W + LUMA_SHIFT;

    // Marker bundle order: {sof, eof, sol, eol}
    logic              w_adv1, w_adv2, w_acc;
    frm_mode_e         w_mode_eff;
    logic [CH_W-1:0]   w_thr_eff;
    logic [SUM_W-1:0]  w_luma;
    logic [DW-1:0]     w_alu_pix;
    logic [IMG_W_W-1:0] w_pos, w_last;

    frm_mode_e         mode_q;
    logic [CH_W-1:0]   thr_q;
    logic [IMG_W_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic              s1_val_q;
    logic [DW-1:0]     s1_data_q;
    logic [3:0]        s1_mk_q;
    frm_mode_e         s1_mode_q;
    logic [CH_W-1:0]   s1_thr_q;
    logic [SUM_W-1:0]  s1_luma_q;

    logic              s2_val_q;
    logic [DW-1:0]     s2_data_q;
    logic [3:0]        s2_mk_q;

    assign w_adv2    = !s2_val_q || s_frm_rdy;
    assign w_adv1    = !s1_val_q || w_adv2;
    assign w_acc     = m_frm_val && w_adv1;
    assign m_frm_rdy = w_adv1;

    // The sof beat uses the live config; every other beat uses the latched one
    assign w_mode_eff = (w_acc && m_frm_sof) ? frm_mode_e'(cfg_mode) : mode_q;
    assign w_thr_eff  = (w_acc && m_frm_sof) ? cfg_thr : thr_q;

    if (CH_NUM >= 3) begin : g_luma
        assign w_luma = SUM_W'(LUMA_R) * SUM_W'(m_frm_data[2*CH_W +: CH_W])
                      + SUM_W'(LUMA_G) * SUM_W'(m_frm_data[1*CH_W +: CH_W])
                      + SUM_W'(LUMA_B) * SUM_W'(m_frm_data[0*CH_W +: CH_W]);
    end else begin : g_no_luma
        assign w_luma = '0;
    end

    // Line-length check: position of this beat in its line, sof restarts at 0
    always_comb begin
        w_pos  = m_frm_sof ? '0 : cnt_q;
        w_last = cfg_img_w - IMG_W_W'(1);
        err_d  = 1'b0;
        cnt_d  = cnt_q;
        if (w_acc) begin
            err_d = m_frm_eol ? (w_pos != w_last) : (w_pos == w_last);
            cnt_d = (m_frm_eol || err_d) ? '0 : w_pos + IMG_W_W'(1);
        end
    end

    assign done_d = s2_val_q && s_frm_rdy && s2_mk_q[2];

    // Config latch, line counter and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_BYP;
            thr_q  <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (w_acc && m_frm_sof) begin
                mode_q <= frm_mode_e'(cfg_mode);
                thr_q  <= cfg_thr;
            end
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            done_q <= done_d;
        end
    end

    // Stage 1: capture the input beat, its effective config and luma sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_val_q  <= 1'b0;
            s1_data_q <= '0;
            s1_mk_q   <= '0;
            s1_mode_q <= MODE_BYP;
            s1_thr_q  <= '0;
            s1_luma_q <= '0;
        end else if (w_adv1) begin
            s1_val_q  <= m_frm_val;
            s1_data_q <= m_frm_data;
            s1_mk_q   <= {m_frm_sof, m_frm_eof, m_frm_sol, m_frm_eol};
            s1_mode_q <= w_mode_eff;
            s1_thr_q  <= w_thr_eff;
            s1_luma_q <= w_luma;
        end
    end

    frm_px_alu #(
        .CH_NUM (CH_NUM),
        .CH_W   (CH_W)
    ) u_alu (
        .mode_i (s1_mode_q),
        .thr_i  (s1_thr_q),
        .pix_i  (s1_data_q),
        .luma_i (s1_luma_q),
        .pix_o  (w_alu_pix)
    );

    // Stage 2: register the result; holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_val_q  <= 1'b0;
            s2_data_q <= '0;
            s2_mk_q   <= '0;
        end else if (w_adv2) begin
            s2_val_q  <= s1_val_q;
            s2_data_q <= w_alu_pix;
            s2_mk_q   <= s1_mk_q;
        end
    end

    assign s_frm_val    = s2_val_q;
    assign s_frm_data   = s2_data_q;
    assign s_frm_sof    = s2_mk_q[3];
    assign s_frm_eof    = s2_mk_q[2];
    assign s_frm_sol    = s2_mk_q[1];
    assign s_frm_eol    = s2_mk_q[0];
    assign err_line_len = err_q;
    assign frm_done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_frm_pixel_op.sv
`default_nettype none
// ============================================================================
// Module      : tb_frm_pixel_op
// Description : Scoreboard bench for frm_pixel_op with a reference model of
//               the point operations, mode latch and line-length rule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frm_pixel_op;

    localparam int CH_NUM  = 3;
    localparam int CH_W    = 8;
    localparam int IMG_W_W = 11;
    localparam int DW      = CH_NUM * CH_W;

    logic clk = 1'b0;
    logic rst_n;
    logic [IMG_W_W-1:0] cfg_img_w;
    logic [1:0]         cfg_mode;
    logic [CH_W-1:0]    cfg_thr;
    logic m_frm_val, m_frm_rdy, m_frm_sof, m_frm_eof, m_frm_sol, m_frm_eol;
    logic [DW-1:0] m_frm_data;
    logic s_frm_val, s_frm_rdy, s_frm_sof, s_frm_eof, s_frm_sol, s_frm_eol;
    logic [DW-1:0] s_frm_data;
    logic err_line_len, frm_done;

    frm_pixel_op #(.CH_NUM(CH_NUM), .CH_W(CH_W), .IMG_W_W(IMG_W_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_img_w(cfg_img_w), .cfg_mode(cfg_mode), .cfg_thr(cfg_thr),
        .m_frm_val(m_frm_val), .m_frm_rdy(m_frm_rdy), .m_frm_data(m_frm_data),
        .m_frm_sof(m_frm_sof), .m_frm_eof(m_frm_eof), .m_frm_sol(m_frm_sol), .m_frm_eol(m_frm_eol),
        .s_frm_val(s_frm_val), .s_frm_rdy(s_frm_rdy), .s_frm_data(s_frm_data),
        .s_frm_sof(s_frm_sof), .s_frm_eof(s_frm_eof), .s_frm_sol(s_frm_sol), .s_frm_eol(s_frm_eol),
        .err_line_len(err_line_len), .frm_done(frm_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [3:0]    mk;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int n_chk = 0, n_err = 0, cyc = 0;
    int m_mode = 0, m_thr = 0, line_px = 0;
    int exp_err = 0, exp_done = 0, dut_err = 0, dut_done = 0;
    bit chk_lat = 0, rdy_rand = 0;
    logic [DW-1:0] last_out = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Reference point operation computed with plain integer arithmetic
    function automatic logic [DW-1:0] ref_px(input int md, input int th, input logic [DW-1:0] px);
        int c[3];
        int y;
        logic [DW-1:0] r;
        for (int k = 0; k < 3; k++) c[k] = int'(px[k*8 +: 8]);
        y = (77 * c[2] + 150 * c[1] + 29 * c[0]) / 256;
        r = px;
        for (int k = 0; k < 3; k++) begin
            case (md)
                1: r[k*8 +: 8] = 8'(255 - c[k]);
                2: r[k*8 +: 8] = (c[k] >= th) ? 8'd255 : 8'd0;
                3: r[k*8 +: 8] = 8'(y);
                default: ;
            endcase
        end
        return r;
    endfunction

    // Input-side monitor: model each accepted beat and queue its expected output
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && m_frm_val && m_frm_rdy) begin
            if (m_frm_sof) begin
                m_mode  = int'(cfg_mode);
                m_thr   = int'(cfg_thr);
                line_px = 0;
            end
            line_px++;
            if (m_frm_eol ? (line_px != int'(cfg_img_w)) : (line_px == int'(cfg_img_w))) begin
                exp_err++;
                line_px = 0;
            end else if (m_frm_eol) begin
                line_px = 0;
            end
            e.d   = ref_px(m_mode, m_thr, m_frm_data);
            e.mk  = {m_frm_sof, m_frm_eof, m_frm_sol, m_frm_eol};
            e.cyc = cyc;
            q.push_back(e);
            if (m_frm_eof) exp_done++;
        end
    end

    // Output-side monitor: compare presented beats against the queue head
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_frm_val) begin
                if (q.size() == 0) begin
                    fail("spurious_output");
                end else begin
                    chk("out_data", 32'(s_frm_data), 32'(q[0].d));
                    chk("out_markers", 32'({s_frm_sof, s_frm_eof, s_frm_sol, s_frm_eol}), 32'(q[0].mk));
                    if (s_frm_rdy) begin
                        if (chk_lat) chk("latency", 32'(cyc - q[0].cyc), 32'd2);
                        last_out = s_frm_data;
                        void'(q.pop_front());
                    end
                end
            end
            if (err_line_len) dut_err++;
            if (frm_done) dut_done++;
        end
    end

    // Output-side ready: held high or randomised each cycle
    initial begin
        s_frm_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            s_frm_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic [3:0] mk);
        int t;
        m_frm_val  = 1'b1;
        m_frm_data = d;
        {m_frm_sof, m_frm_eof, m_frm_sol, m_frm_eol} = mk;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!m_frm_rdy && t < 1000);
        if (!m_frm_rdy) fail("send_timeout");
        @(posedge clk);
        #1;
        m_frm_val = 1'b0;
        {m_frm_sof, m_frm_eof, m_frm_sol, m_frm_eol} = 4'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int w, input int h, input int md, input int th,
                              input bit gaps, input bit mid_cfg);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (x == 0 && y == 0) begin
                    cfg_mode = 2'(md);
                    cfg_thr  = 8'(th);
                end else if (mid_cfg) begin
                    cfg_mode = 2'($urandom);
                    cfg_thr  = 8'($urandom);
                end
                send(DW'($urandom), {(x == 0 && y == 0), (x == w-1 && y == h-1), (x == 0), (x == w-1)});
                if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        if (q.size() != 0) fail("drain_timeout");
        idle(3);
    endtask

    task automatic checkpoint(input string nm);
        chk({nm, "_err_count"}, 32'(dut_err), 32'(exp_err));
        chk({nm, "_done_count"}, 32'(dut_done), 32'(exp_done));
    endtask

    task automatic one_px(input int md, input int th, input logic [DW-1:0] d);
        cfg_mode = 2'(md);
        cfg_thr  = 8'(th);
        send(d, 4'b1111);
        drain();
    endtask

    initial begin
        logic [DW-1:0] d_last;
        int e0, w;
        rst_n = 1'b0;
        cfg_img_w = 11'd4; cfg_mode = 2'd0; cfg_thr = 8'd0;
        m_frm_val = 1'b0; m_frm_data = '0;
        {m_frm_sof, m_frm_eof, m_frm_sol, m_frm_eol} = 4'b0;
        idle(3);
        chk("rst_s_val", 32'(s_frm_val), 32'd0);
        chk("rst_s_data", 32'(s_frm_data), 32'd0);
        chk("rst_s_markers", 32'({s_frm_sof, s_frm_eof, s_frm_sol, s_frm_eol}), 32'd0);
        chk("rst_err_done", 32'({err_line_len, frm_done}), 32'd0);
        chk("rst_m_rdy", 32'(m_frm_rdy), 32'd1);
        rst_n = 1'b1;
        idle(2);

        // Bypass 4x2 frame, ready held high, latency checked
        chk_lat = 1;
        send_frame(4, 2, 0, 0, 0, 0);
        drain();
        chk_lat = 0;
        checkpoint("bypass");
        chk("bypass_done_once", 32'(dut_done), 32'd1);

        // Directed single-pixel frames
        cfg_img_w = 11'd1;
        one_px(1, 0, 24'h102030);    chk("negate_px", 32'(last_out), 32'h00EFDFCF);
        one_px(2, 8'h80, 24'h7F8081); chk("thresh_px", 32'(last_out), 32'h0000FFFF);
        one_px(3, 0, 24'hFFFFFF);    chk("gray_white", 32'(last_out), 32'h00FFFFFF);
        one_px(3, 0, 24'h640000);    chk("gray_red", 32'(last_out), 32'h001E1E1E);
        checkpoint("directed");

        // Random frames with backpressure, gaps and mid-frame config churn
        rdy_rand = 1;
        for (int f = 0; f < 14; f++) begin
            w = $urandom_range(1, 6);
            cfg_img_w = 11'(($urandom_range(0, 3) == 0) ? w + 1 : w);
            send_frame(w, $urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(0, 255), 1, 1);
        end
        drain();
        rdy_rand = 0;
        idle(2);
        checkpoint("random");

        // Short line: eol on the 3rd pixel with a 4-pixel line length
        cfg_img_w = 11'd4;
        e0 = dut_err;
        cfg_mode = 2'd0;
        send(24'h000001, 4'b1010);
        send(24'h000002, 4'b0000);
        send(24'h000003, 4'b0101);
        drain();
        chk("short_line_pulses", 32'(dut_err - e0), 32'd1);
        checkpoint("line");

        // Reset mid-frame with beats in flight
        send_frame(3, 1, 1, 0, 0, 0);
        cfg_img_w = 11'd4;
        cfg_mode  = 2'd1;
        send(DW'($urandom), 4'b1010);
        send(DW'($urandom), 4'b0000);
        send(DW'($urandom), 4'b0000);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_s_val", 32'(s_frm_val), 32'd0);
        chk("midrst_s_data", 32'(s_frm_data), 32'd0);
        q.delete();
        m_mode = 0; m_thr = 0; line_px = 0;
        exp_err = 0; exp_done = 0; dut_err = 0; dut_done = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Beats without sof after reset run in bypass
        cfg_mode = 2'd1;
        for (int i = 0; i < 4; i++) begin
            d_last = DW'($urandom);
            send(d_last, {2'b00, (i == 0), (i == 3)});
        end
        drain();
        chk("post_rst_bypass", 32'(last_out), 32'(d_last));
        cfg_img_w = 11'd1;
        one_px(1, 0, 24'h102030);
        chk("post_rst_sof_negate", 32'(last_out), 32'h00EFDFCF);
        checkpoint("post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Global bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL global_timeout (t=%0t)", $time);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
